// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial add sequencer driving an external 1-bit full-adder slice
// Optional macro: SERIAL_ADD_OVF_EN adds the out_ovf signed-overflow output.

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_ci,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_ci,
  input  logic             fa_s,
  input  logic             fa_co,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_co,
`ifdef SERIAL_ADD_OVF_EN
  output logic             out_ovf,
`endif
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_sum_sr;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic             w_last;
  logic [WIDTH:0]   w_sum_cat;

  // Final bit position reached; the shift taken this cycle completes the sum.
  assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));
  // New sum bit enters at the MSB end so bit 0 lands at position 0 after WIDTH shifts.
  assign w_sum_cat = {fa_s, r_sum_sr};

  assign out_sum = r_sum_sr;
  assign out_co  = r_carry;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and handshake/slice outputs; slice inputs come from flops only.
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    fa_a      = 1'b0;
    fa_b      = 1'b0;
    fa_ci     = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = rst_n;
        if (in_valid && rst_n) begin
          w_next = S_RUN;
        end
      end
      S_RUN: begin
        busy  = 1'b1;
        fa_a  = r_a_sr[0];
        fa_b  = r_b_sr[0];
        fa_ci = r_carry;
        if (w_last) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Operand capture, LSB-first shifting, carry and sum assembly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_sum_sr <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a_sr  <= in_a;
            r_b_sr  <= in_b;
            r_carry <= in_ci;
            r_cnt   <= '0;
          end
        end
        S_RUN: begin
          r_sum_sr <= w_sum_cat[WIDTH:1];
          r_a_sr   <= r_a_sr >> 1;
          r_b_sr   <= r_b_sr >> 1;
          r_carry  <= fa_co;
          r_cnt    <= r_cnt + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  logic r_ovf;

  assign out_ovf = r_ovf;

  // Signed overflow: carry into the MSB differs from carry out of the MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (r_state == S_RUN && w_last) begin
      r_ovf <= fa_ci ^ fa_co;
    end
  end
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - directed self-checking bench for serial_add_ctrl

module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       in_ci;
  logic       fa_a;
  logic       fa_b;
  logic       fa_ci;
  logic       fa_s;
  logic       fa_co;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_sum;
  logic       out_co;
  logic       busy;
`ifdef SERIAL_ADD_OVF_EN
  logic       out_ovf;
`endif

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  // Behavioural stand-in for the external gate-level slice.
  assign fa_s  = fa_a ^ fa_b ^ fa_ci;
  assign fa_co = (fa_a & fa_b) | (fa_a & fa_ci) | (fa_b & fa_ci);

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_ci     (in_ci),
    .fa_a      (fa_a),
    .fa_b      (fa_b),
    .fa_ci     (fa_ci),
    .fa_s      (fa_s),
    .fa_co     (fa_co),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_co    (out_co),
`ifdef SERIAL_ADD_OVF_EN
    .out_ovf   (out_ovf),
`endif
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Present an operand pair, wait for the accept edge, return at the next negedge.
  task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic ci);
    @(negedge clk);
    in_a     = a;
    in_b     = b;
    in_ci    = ci;
    in_valid = 1'b1;
    chk("in_ready_pre", in_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("busy_run", busy, 1'b1);
    chk("in_ready_run", in_ready, 1'b0);
  endtask

  // Count edges after the accept edge until out_valid, recording fa_a per RUN cycle.
  task automatic wait_done(input logic [7:0] es, input logic eco, output logic [7:0] seq);
    int edges;
    edges = 0;
    seq   = '0;
    while (!out_valid && edges < 20) begin
      if (edges < 8) seq[edges] = fa_a;
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    chk("out_valid", out_valid, 1'b1);
    chk("latency", edges, 8);
    chk("out_sum", out_sum, es);
    chk("out_co", out_co, eco);
    chk("fa_a_done", fa_a, 1'b0);
  endtask

  task automatic ack;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_ack", out_valid, 1'b0);
    chk("in_ready_ack", in_ready, 1'b1);
    chk("busy_ack", busy, 1'b0);
  endtask

  task automatic run_add(input logic [7:0] a, input logic [7:0] b, input logic ci,
                         input logic [7:0] es, input logic eco);
    logic [7:0] seq;
    start_op(a, b, ci);
    wait_done(es, eco, seq);
    ack();
  endtask

  initial begin
    logic [7:0] seq;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_ci     = 1'b0;
    out_ready = 1'b0;

    #12;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_fa", {fa_a, fa_b, fa_ci}, 3'b000);
    chk("rst_out_sum", out_sum, 8'h00);
    chk("rst_out_co", out_co, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);

    // Basic add with fa_a bit order check.
    start_op(8'h5A, 8'h33, 1'b0);
    wait_done(8'h8D, 1'b0, seq);
    chk("fa_a_seq", seq, 8'h5A);
    ack();

    // Carry ripple cases.
    run_add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run_add(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1);
    run_add(8'hC8, 8'h64, 1'b1, 8'h2D, 1'b1);

    // Backpressure: result held, new requests ignored.
    start_op(8'h12, 8'h34, 1'b0);
    wait_done(8'h46, 1'b0, seq);
    in_a = 8'hFF;
    in_b = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      @(posedge clk);
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1'b1);
      chk("bp_out_sum", out_sum, 8'h46);
      chk("bp_out_co", out_co, 1'b0);
      chk("bp_in_ready", in_ready, 1'b0);
    end
    in_valid = 1'b0;
    ack();
    chk("bp_idle_out_valid", out_valid, 1'b0);
    run_add(8'h21, 8'h10, 1'b0, 8'h31, 1'b0);

    // Asynchronous reset three cycles into RUN.
    start_op(8'hFF, 8'hFF, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_fa", {fa_a, fa_b, fa_ci}, 3'b111);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_fa", {fa_a, fa_b, fa_ci}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1'b1);
    run_add(8'h01, 8'h01, 1'b0, 8'h02, 1'b0);

`ifdef SERIAL_ADD_OVF_EN
    start_op(8'h7F, 8'h01, 1'b0);
    wait_done(8'h80, 1'b0, seq);
    chk("ovf_7f_01", out_ovf, 1'b1);
    ack();
    start_op(8'h80, 8'h80, 1'b0);
    wait_done(8'h00, 1'b1, seq);
    chk("ovf_80_80", out_ovf, 1'b1);
    ack();
    start_op(8'h10, 8'h20, 1'b0);
    wait_done(8'h30, 1'b0, seq);
    chk("ovf_10_20", out_ovf, 1'b0);
    ack();
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
